dp_exec_ctrl: RTL

- Sequences one ARM data-processing instruction at a time through the shared ALU.
- Evaluates the condition field against the CPSR flags it owns, reads Rn/Rm from the register file, and drives the ALU operands and control.
- Captures the result, writes Rd back (or raises a PC write when Rd is r15), and updates NZCV when S=1 or for TST/TEQ/CMP/CMN.
- Sits between the decode stage and the ALU / register file.

---
 rtl/arm_dp_pkg.sv | 63 ++++++
 rtl/cond_check.sv | 40 ++++
 rtl/dp_exec_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/arm_dp_pkg.sv
// Shared constants, FSM state type and opcode classifiers for the ARM data-processing controller.
package arm_dp_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_EOR = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_ADC = 4'd5;
  localparam logic [3:0] OP_SBC = 4'd6;
  localparam logic [3:0] OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8;
  localparam logic [3:0] OP_TEQ = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12;
  localparam logic [3:0] OP_MOV = 4'd13;
  localparam logic [3:0] OP_BIC = 4'd14;
  localparam logic [3:0] OP_MVN = 4'd15;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, SKIP} state_t;

  // Compare-type ops: flags only, never a register write.
  function automatic logic is_test_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_TST, OP_TEQ, OP_CMP, OP_CMN: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

  // Logical ops take C from the shifter and leave V alone.
  function automatic logic is_logical_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_AND, OP_EOR, OP_TST, OP_TEQ,
      OP_ORR, OP_MOV, OP_BIC, OP_MVN: r = 1'b1;
      OP_SUB, OP_RSB, OP_ADD, OP_ADC,
      OP_SBC, OP_RSC, OP_CMP, OP_CMN: r = 1'b0;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluation against NZCV ({N,Z,C,V}).
module cond_check
  import arm_dp_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[3];
  assign z = nzcv[2];
  assign c = nzcv[1];
  assign v = nzcv[0];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/dp_exec_ctrl.sv
// Sequences one data-processing instruction through the shared ALU and register file,
// owning the CPSR NZCV flags.
module dp_exec_ctrl
  import arm_dp_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    cond,
  input  logic [3:0]    opcode,
  input  logic          s_bit,
  input  logic [RW-1:0] rd,
  input  logic [RW-1:0] rn,
  input  logic [RW-1:0] rm,
  input  logic          op2_is_imm,
  input  logic [DW-1:0] op2_imm,
  input  logic          sh_carry,
  output logic [RW-1:0] rf_raddr_a,
  output logic [RW-1:0] rf_raddr_b,
  input  logic [DW-1:0] rf_rdata_a,
  input  logic [DW-1:0] rf_rdata_b,
  output logic [DW-1:0] alu_operand_a,
  output logic [DW-1:0] alu_operand_b,
  output logic [3:0]    alu_control,
  output logic          alu_carry_in,
  input  logic [DW-1:0] alu_result,
  input  logic [3:0]    alu_nzcv,
  output logic          rf_we,
  output logic [RW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          pc_we,
  output logic [3:0]    nzcv_q,
  output logic          done,
  output logic          executed
);

  state_t        state, state_d;
  logic          cond_pass;
  logic          accept, load_ops, capture, flag_we;
  logic [3:0]    nzcv_d;
  logic [3:0]    opcode_q;
  logic          s_q, imm_sel_q, shc_q;
  logic [DW-1:0] imm_q;
  logic [3:0]    cap_nzcv_q;

  cond_check u_cond_check (
    .cond (cond),
    .nzcv (nzcv_q),
    .pass (cond_pass)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next state, state-decoded strobes and the WB flag merge.
  always_comb begin
    state_d     = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    executed    = 1'b0;
    rf_we       = 1'b0;
    pc_we       = 1'b0;
    accept      = 1'b0;
    load_ops    = 1'b0;
    capture     = 1'b0;
    flag_we     = 1'b0;
    nzcv_d      = nzcv_q;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept  = 1'b1;
          state_d = cond_pass ? READ : SKIP;
        end
      end
      READ: begin
        load_ops = 1'b1;
        state_d  = EXEC;
      end
      EXEC: begin
        capture = 1'b1;
        state_d = WB;
      end
      WB: begin
        done     = 1'b1;
        executed = 1'b1;
        if (!is_test_op(opcode_q)) begin
          if (rf_waddr == RW'(15)) pc_we = 1'b1;
          else                     rf_we = 1'b1;
        end
        if (s_q || is_test_op(opcode_q)) begin
          flag_we = 1'b1;
          nzcv_d  = is_logical_op(opcode_q) ? {cap_nzcv_q[3:2], shc_q, nzcv_q[0]}
                                            : cap_nzcv_q;
        end
        state_d = IDLE;
      end
      SKIP: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Instruction latch, operand staging, result capture and CPSR flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opcode_q      <= '0;
      s_q           <= 1'b0;
      imm_sel_q     <= 1'b0;
      imm_q         <= '0;
      shc_q         <= 1'b0;
      rf_raddr_a    <= '0;
      rf_raddr_b    <= '0;
      rf_waddr      <= '0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_control   <= '0;
      alu_carry_in  <= 1'b0;
      rf_wdata      <= '0;
      cap_nzcv_q    <= '0;
      nzcv_q        <= '0;
    end else begin
      if (accept) begin
        opcode_q   <= opcode;
        s_q        <= s_bit;
        imm_sel_q  <= op2_is_imm;
        imm_q      <= op2_imm;
        shc_q      <= sh_carry;
        rf_raddr_a <= rn;
        rf_raddr_b <= rm;
        rf_waddr   <= rd;
      end
      if (load_ops) begin
        alu_operand_a <= rf_rdata_a;
        alu_operand_b <= imm_sel_q ? imm_q : rf_rdata_b;
        alu_control   <= opcode_q;
        alu_carry_in  <= nzcv_q[1];
      end
      if (capture) begin
        rf_wdata   <= alu_result;
        cap_nzcv_q <= alu_nzcv;
      end
      if (flag_we) nzcv_q <= nzcv_d;
    end
  end

endmodule
